// File: rtl/bus_responder.sv
// hmc-6502 bus target: RAM, reset/IRQ vectors, TX FIFO and RX holding register.
// One bus access per ph2 cycle; read data is combinational, writes commit on the edge.
module bus_responder #(
   parameter int unsigned RAM_AW       = 9,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [15:0] RESET_VECTOR = 16'h0200,
   parameter logic [15:0] IRQ_VECTOR   = 16'h0300
) (
   input  logic        ph2,
   input  logic        reset,
   input  logic [15:0] address,
   inout  wire  [7:0]  data,
   input  logic        read_en,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [15:0] A_TXD   = 16'hF000;
   localparam logic [15:0] A_STAT  = 16'hF001;
   localparam logic [15:0] A_RXD   = 16'hF002;
   localparam logic [15:0] A_TXCNT = 16'hF003;
   localparam logic [15:0] A_RVL   = 16'hFFFC;
   localparam logic [15:0] A_RVH   = 16'hFFFD;
   localparam logic [15:0] A_IVL   = 16'hFFFE;
   localparam logic [15:0] A_IVH   = 16'hFFFF;

   logic [7:0]    r_mem [2**RAM_AW];
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [7:0]    r_rx_data;
   logic          r_rx_full;

   logic          w_ram_sel;
   logic          w_sel_txd;
   logic          w_sel_stat;
   logic          w_sel_rxd;
   logic          w_sel_txcnt;
   logic          w_sel_rvl;
   logic          w_sel_rvh;
   logic          w_sel_ivl;
   logic          w_sel_ivh;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push_req;
   logic          w_push;
   logic          w_rxd_pop;
   logic [7:0]    w_stat;
   logic [7:0]    w_txcnt;
   logic [7:0]    w_rd_data;

   assign w_ram_sel   = (address >> RAM_AW) == 16'h0000;
   assign w_sel_txd   = address == A_TXD;
   assign w_sel_stat  = address == A_STAT;
   assign w_sel_rxd   = address == A_RXD;
   assign w_sel_txcnt = address == A_TXCNT;
   assign w_sel_rvl   = address == A_RVL;
   assign w_sel_rvh   = address == A_RVH;
   assign w_sel_ivl   = address == A_IVL;
   assign w_sel_ivh   = address == A_IVH;

   assign w_empty    = r_count == '0;
   assign w_full     = r_count == DEPTH_C;
   assign w_pop      = !w_empty && tx_ready;
   assign w_push_req = !read_en && w_sel_txd;
   // A full FIFO still takes the byte when the sink frees a slot this cycle
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_rxd_pop  = read_en && w_sel_rxd && r_rx_full;

   assign tx_valid = !w_empty;
   assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr];
   assign rx_ready = !r_rx_full;

   always_ff @(posedge ph2) begin
      if (!read_en && w_ram_sel) begin
         r_mem[address[RAM_AW-1:0]] <= data;
      end
   end

   always_ff @(posedge ph2) begin
      if (w_push) begin
         r_fifo[r_wptr] <= data;
      end
   end

   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_push_req && !w_push) begin
            r_overflow <= 1'b1;
         end else if (!read_en && w_sel_stat) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // A CPU pop wins over a source offer; rx_ready was low that cycle
   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         r_rx_data <= 8'h00;
         r_rx_full <= 1'b0;
      end else if (w_rxd_pop) begin
         r_rx_full <= 1'b0;
      end else if (!r_rx_full && rx_valid) begin
         r_rx_data <= rx_data;
         r_rx_full <= 1'b1;
      end
   end

   assign w_stat  = {4'b0000, r_overflow, r_rx_full, w_full, w_empty};
   assign w_txcnt = {{(8-CW){1'b0}}, r_count};

   always_comb begin
      w_rd_data = 8'hFF;
      unique case (1'b1)
         w_ram_sel:   w_rd_data = r_mem[address[RAM_AW-1:0]];
         w_sel_txd:   w_rd_data = 8'h00;
         w_sel_stat:  w_rd_data = w_stat;
         w_sel_rxd:   w_rd_data = r_rx_data;
         w_sel_txcnt: w_rd_data = w_txcnt;
         w_sel_rvl:   w_rd_data = RESET_VECTOR[7:0];
         w_sel_rvh:   w_rd_data = RESET_VECTOR[15:8];
         w_sel_ivl:   w_rd_data = IRQ_VECTOR[7:0];
         w_sel_ivh:   w_rd_data = IRQ_VECTOR[15:8];
         default:     w_rd_data = 8'hFF;
      endcase
   end

   assign data = read_en ? w_rd_data : 8'hzz;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: directed plan followed by random bus traffic.
// A queue-based reference model predicts read data, handshakes and the TX byte stream.
module tb_bus_responder;

   localparam int D = 4;

   logic        ph2 = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address;
   logic        read_en;
   logic [7:0]  wdata;
   wire  [7:0]  data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   assign data = read_en ? 8'hzz : wdata;

   always #5 ph2 = ~ph2;

   bus_responder #(
      .RAM_AW(9),
      .FIFO_DEPTH(D),
      .RESET_VECTOR(16'h0200),
      .IRQ_VECTOR(16'h0300)
   ) dut (
      .ph2(ph2),
      .reset(reset),
      .address(address),
      .data(data),
      .read_en(read_en),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready)
   );

   typedef struct {
      logic        rd;
      logic [15:0] a;
      logic [7:0]  rdv;
      logic        txv;
      logic        rxr;
   } exp_t;

   exp_t       cyc_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] m_fifo[$];
   logic       m_ovf;
   logic       m_rxf;
   logic [7:0] m_rx;
   logic [7:0] m_ram[512];
   bit         m_ramv[512];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [15:0] a);
      if (a < 16'd512) return m_ram[a[8:0]];
      case (a)
         16'hF000: return 8'h00;
         16'hF001: return {4'b0000, m_ovf, m_rxf,
                           m_fifo.size() == D, m_fifo.size() == 0};
         16'hF002: return m_rx;
         16'hF003: return 8'(m_fifo.size());
         16'hFFFC: return 8'h00;
         16'hFFFD: return 8'h02;
         16'hFFFE: return 8'h00;
         16'hFFFF: return 8'h03;
         default:  return 8'hFF;
      endcase
   endfunction

   task automatic cycle(input logic rd, input logic [15:0] a, input logic [7:0] wd,
                        input logic txr, input logic rxv, input logic [7:0] rxd);
      exp_t e;
      bit   pop;
      bit   acc;
      @(posedge ph2);
      #1;
      address  = a;
      read_en  = rd;
      wdata    = wd;
      tx_ready = txr;
      rx_valid = rxv;
      rx_data  = rxd;
      e.rd  = rd;
      e.a   = a;
      e.rdv = m_read(a);
      e.txv = m_fifo.size() > 0;
      e.rxr = !m_rxf;
      cyc_q.push_back(e);
      pop = txr && (m_fifo.size() > 0);
      acc = 1'b0;
      if (!rd) begin
         if (a < 16'd512) begin
            m_ram[a[8:0]]  = wd;
            m_ramv[a[8:0]] = 1'b1;
         end
         if (a == 16'hF000) begin
            if (m_fifo.size() < D || pop) acc = 1'b1;
            else m_ovf = 1'b1;
         end
         if (a == 16'hF001) m_ovf = 1'b0;
      end
      if (rd && a == 16'hF002 && m_rxf) m_rxf = 1'b0;
      else if (!m_rxf && rxv) begin
         m_rxf = 1'b1;
         m_rx  = rxd;
      end
      if (pop) void'(m_fifo.pop_front());
      if (acc) begin
         m_fifo.push_back(wd);
         tx_q.push_back(wd);
      end
   endtask

   task automatic rd_c(input logic [15:0] a);
      cycle(1'b1, a, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic wr_c(input logic [15:0] a, input logic [7:0] d);
      cycle(1'b0, a, d, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic reset_mid();
      @(posedge ph2);
      #1;
      address  = 16'h0400;
      read_en  = 1'b1;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      #1;
      chk1("tx_valid_before_rst", tx_valid, m_fifo.size() > 0);
      #1;
      reset = 1'b1;
      #1;
      chk1("tx_valid_in_rst", tx_valid, 1'b0);
      chk1("rx_ready_in_rst", rx_ready, 1'b1);
      chk("tx_data_in_rst", tx_data, 8'h00);
      @(posedge ph2);
      #3;
      reset = 1'b0;
      m_fifo.delete();
      tx_q.delete();
      m_ovf = 1'b0;
      m_rxf = 1'b0;
      m_rx  = 8'h00;
   endtask

   always @(negedge ph2) begin
      exp_t       e;
      logic [7:0] b;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         chk1("tx_valid", tx_valid, e.txv);
         chk1("rx_ready", rx_ready, e.rxr);
         if (e.rd) chk($sformatf("read_%04h", e.a), data, e.rdv);
      end
      if (!reset && tx_valid && tx_ready) begin
         if (tx_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_stream: got %02h expected no byte", tx_data);
         end else begin
            b = tx_q.pop_front();
            chk("tx_stream", tx_data, b);
         end
      end
   end

   initial begin
      int          k;
      logic        rd;
      logic [15:0] a;
      address  = 16'h0400;
      read_en  = 1'b1;
      wdata    = 8'h00;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      m_ovf    = 1'b0;
      m_rxf    = 1'b0;
      m_rx     = 8'h00;
      repeat (2) @(posedge ph2);
      #3 reset = 1'b0;
      @(negedge ph2);
      chk1("rst_tx_valid", tx_valid, 1'b0);
      chk1("rst_rx_ready", rx_ready, 1'b1);
      chk("rst_tx_data", tx_data, 8'h00);

      rd_c(16'hFFFC);
      rd_c(16'hFFFD);
      rd_c(16'hFFFE);
      rd_c(16'hFFFF);
      rd_c(16'hF001);

      wr_c(16'h0010, 8'hA5);
      wr_c(16'h01FF, 8'h5A);
      rd_c(16'h0010);
      rd_c(16'h01FF);
      rd_c(16'h0400);
      wr_c(16'hF003, 8'h77);
      rd_c(16'hF003);

      wr_c(16'hF000, 8'h11);
      wr_c(16'hF000, 8'h22);
      wr_c(16'hF000, 8'h33);
      wr_c(16'hF000, 8'h44);
      wr_c(16'hF000, 8'h55);
      rd_c(16'hF003);
      rd_c(16'hF001);
      repeat (6) cycle(1'b1, 16'h0400, 8'h00, 1'b1, 1'b0, 8'h00);
      wr_c(16'hF001, 8'h00);
      rd_c(16'hF001);

      wr_c(16'hF000, 8'hA1);
      wr_c(16'hF000, 8'hA2);
      wr_c(16'hF000, 8'hA3);
      wr_c(16'hF000, 8'hA4);
      cycle(1'b0, 16'hF000, 8'h66, 1'b1, 1'b0, 8'h00);
      rd_c(16'hF003);
      rd_c(16'hF001);
      repeat (6) cycle(1'b1, 16'h0400, 8'h00, 1'b1, 1'b0, 8'h00);

      cycle(1'b1, 16'h0400, 8'h00, 1'b0, 1'b1, 8'h3C);
      cycle(1'b1, 16'hF001, 8'h00, 1'b0, 1'b1, 8'h7E);
      cycle(1'b1, 16'hF002, 8'h00, 1'b0, 1'b1, 8'h7E);
      cycle(1'b1, 16'hF001, 8'h00, 1'b0, 1'b1, 8'h7E);
      rd_c(16'hF001);
      rd_c(16'hF002);
      rd_c(16'hF002);

      wr_c(16'h0020, 8'h99);
      wr_c(16'hF000, 8'hC1);
      wr_c(16'hF000, 8'hC2);
      reset_mid();
      rd_c(16'hF003);
      rd_c(16'h0020);
      rd_c(16'hF001);

      for (int i = 0; i < 600; i++) begin
         k  = $urandom_range(0, 10);
         rd = 1'($urandom_range(0, 1));
         case (k)
            0, 1, 2: a = 16'($urandom_range(0, 511));
            3, 4:    a = 16'hF000;
            5:       a = 16'hF001;
            6:       a = 16'hF002;
            7:       a = 16'hF003;
            8:       a = 16'hFFFC + 16'($urandom_range(0, 3));
            default: a = 16'($urandom_range(16'h0200, 16'hEFFF));
         endcase
         if (a < 16'd512 && !m_ramv[a[8:0]]) rd = 1'b0;
         if (k == 5 && $urandom_range(0, 3) != 0) rd = 1'b1;
         cycle(rd, a, 8'($urandom), $urandom_range(0, 2) == 0,
               1'($urandom_range(0, 1)), 8'($urandom));
      end

      for (int i = 0; i < 20 && m_fifo.size() > 0; i++) begin
         cycle(1'b1, 16'h0400, 8'h00, 1'b1, 1'b0, 8'h00);
      end
      cycle(1'b1, 16'hF003, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge ph2);
      @(negedge ph2);
      chk("tx_stream_left", 8'(tx_q.size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory/I-O responder for the hmc-6502 external bus: the target end of the `address` / `data` / `read_en` interface the CPU chip drives. It decodes every bus cycle and serves a RAM region, reset/IRQ vectors and four memory-mapped I/O registers. The I/O registers are a transmit FIFO draining to a valid/ready sink and a one-entry receive register filled from a valid/ready source. It sits on the board/testbench side of the chip pins, one bus access per clock.

## Interface
- `RAM_AW`, 9: RAM address width; RAM occupies 0x0000 to 2^RAM_AW−1.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `RESET_VECTOR`, 16'h0200: value returned at 0xFFFC (low byte) and 0xFFFD (high byte).
- `IRQ_VECTOR`, 16'h0300: value returned at 0xFFFE (low byte) and 0xFFFF (high byte).
- `ph2` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 16: CPU bus address.
- `data` inout 8: driven by this block only when `read_en`=1, otherwise high-Z.
- `read_en` in 1: 1 = CPU read cycle, 0 = CPU write cycle.
- `tx_data` out 8: head of TX FIFO.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: sink accepts head; pop when `tx_valid`&`tx_ready`.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: source offers byte.
- `rx_ready` out 1: equals !rx_full; capture when `rx_valid`&`rx_ready`.

## Operation
- Every clock is one bus access; the decode of `address` selects the target.
  - RAM range: read returns mem[address]; write stores data.
  - 0xF000 TXD: write pushes data into TX FIFO; read returns 8'h00.
  - 0xF001 STAT: read returns {4'b0, overflow, rx_full, tx_full, tx_empty}; a write of any value clears overflow.
  - 0xF002 RXD: read returns rx register and clears rx_full (pop); write is ignored.
  - 0xF003 TXCNT: read returns zero-extended FIFO occupancy (0..FIFO_DEPTH); write is ignored.
  - 0xFFFC–0xFFFF: vector bytes as parameterised; writes are ignored.
- All other addresses read 8'hFF; writes to them are ignored.
- RAM is not reset; its contents are undefined until written.
- TX FIFO:
  - Push when full sets overflow and drops the byte, unless a sink pop happens in the same cycle, in which case the push is accepted.
  - Push and pop in the same cycle when not full: occupancy is unchanged, order is preserved.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits.
- RX register:
  - When !rx_full and `rx_valid`=1: capture `rx_data`, set rx_full.
  - A CPU read of RXD with rx_full=0 returns the stale value and has no effect.
  - A CPU RXD read and a source offer in the same cycle: the pop clears rx_full and the offer is not accepted that cycle, because `rx_ready` was 0.
- Reset values:
  - TX FIFO empty, so `tx_valid`=0 and `tx_data`=8'h00.
  - overflow=0, rx_full=0, so `rx_ready`=1.
  - rx register = 8'h00.
  - Pointers and count are 0.
  - `data` is high-Z whenever `read_en`=0.
- `reset` asserted mid-operation clears all of the above immediately, discards FIFO contents and leaves RAM untouched.

## Timing
- Read data is combinational from `address`/`read_en` in the same cycle, with zero wait states.
- Read side effects (RXD pop) and all writes commit at the rising `ph2` edge ending the cycle.
- A push into an empty FIFO raises `tx_valid` the cycle after the push edge; there is no fall-through.
- After a sink pop, `tx_data` shows the next entry in the following cycle.
- After an RX capture, rx_full and STAT bit2 read 1 starting the next cycle, and `rx_ready`=0 in that same cycle.
- The STAT value read reflects state before the current edge.

## Test plan
- Reset, then read 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF -> 8'h00, 8'h02, 8'h00, 8'h03; STAT read -> 8'h01; `tx_valid`=0, `rx_ready`=1.
- Write 8'hA5 to 0x0010 and 8'h5A to 0x01FF, then read both -> A5, 5A. Read 0x0400 -> FF. Write then read 0xF003 -> 00.
- With `tx_ready`=0, push 11, 22, 33, 44, 55 to 0xF000 -> TXCNT=4, STAT=8'h0A (overflow, full). Raise `tx_ready` -> sink sees 11, 22, 33, 44 on consecutive cycles, 55 never. Write 0xF001 -> STAT=8'h01.
- FIFO full and `tx_ready`=1: push 66 in the same cycle -> accepted, TXCNT stays 4, overflow stays 0, and 66 arrives last.
- `rx_valid`=1 with `rx_data`=3C -> next cycle `rx_ready`=0 and STAT=8'h05. Offer 7E while full -> not taken. Read 0xF002 -> 3C, then 7E is captured the cycle after.
- Push 2 bytes, assert `reset` asynchronously between edges -> `tx_valid` drops immediately and TXCNT=0. RAM byte written before reset still reads back.
